// File: rtl/tile_frame_renderer_if.sv
// Tile colour memory write port: valid/ready handshake carrying a tile index and its colour.
interface tile_frame_renderer_if #(
   parameter int AW      = 8,
   parameter int COLOR_W = 12
);
   logic               wr_valid;
   logic               wr_ready;
   logic [AW-1:0]      wr_addr;
   logic [COLOR_W-1:0] wr_color;

   modport master (output wr_valid, output wr_addr, output wr_color, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_color, output wr_ready);
endinterface

// File: rtl/tile_frame_renderer.sv
// Frame renderer: on frame_start, snapshots game state and writes every tile colour in raster order.
//
// state | meaning
// IDLE  | waiting for frame_start; shadow registers loaded on accept
// FETCH | enemy RAM address presented for the current tile
// WRITE | tile write offered on the write port until wr_ready
// DONE  | frame_done pulse, then back to IDLE
module tile_frame_renderer #(
   parameter int COLS          = 16,
   parameter int ROWS          = 12,
   parameter int NUM_BULLETS   = 3,
   parameter int ENEMY_ROWS    = 5,
   parameter int ENEMY_COLS    = 6,
   parameter int ENEMY_COL_MIN = 4,
   parameter int PLAYER_COL    = 1,
   parameter int COLOR_W       = 12,
   parameter logic [COLOR_W-1:0] HOME_COLOR   = 12'h282,
   parameter logic [COLOR_W-1:0] PLAYER_COLOR = 12'hFFF,
   localparam int XW  = $clog2(COLS),
   localparam int YW  = $clog2(ROWS),
   localparam int AW  = $clog2(COLS*ROWS),
   localparam int EAW = $clog2(ENEMY_ROWS*ENEMY_COLS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           frame_start,
   input  logic [YW-1:0]                  player_row,
   input  logic [NUM_BULLETS*XW-1:0]      bullet_x,
   input  logic [NUM_BULLETS*YW-1:0]      bullet_y,
   input  logic [NUM_BULLETS*COLOR_W-1:0] bullet_color,
   output logic [EAW-1:0]                 enemy_rd_addr,
   input  logic [COLOR_W-1:0]             enemy_rd_data,
   tile_frame_renderer_if.master          wr,
   output logic                           busy,
   output logic                           frame_done,
   output logic                           overrun
);

   localparam logic [XW-1:0] LAST_COL = XW'(COLS-1);
   localparam logic [YW-1:0] LAST_ROW = YW'(ROWS-1);
   localparam logic [XW-1:0] PCOL     = XW'(PLAYER_COL);

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

   state_t                           state_q, state_d;
   logic [XW-1:0]                    col_q;
   logic [YW-1:0]                    row_q;
   logic [AW-1:0]                    addr_q;
   logic [YW-1:0]                    prow_q;
   logic [NUM_BULLETS*XW-1:0]        bx_q;
   logic [NUM_BULLETS*YW-1:0]        by_q;
   logic [NUM_BULLETS*COLOR_W-1:0]   bc_q;
   logic                             held_q;
   logic [COLOR_W-1:0]               enemy_q;
   logic                             overrun_q;
   logic                             accept;
   logic                             is_last;
   logic                             is_enemy;
   logic                             fixed_hit;
   logic [COLOR_W-1:0]               fixed_color;
   logic [31:0]                      er, ec;

   assign is_last    = (row_q == LAST_ROW) && (col_q == LAST_COL);
   assign busy       = (state_q != IDLE);
   assign overrun    = overrun_q;
   assign wr.wr_addr = addr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         addr_q    <= '0;
         prow_q    <= '0;
         bx_q      <= '0;
         by_q      <= '0;
         bc_q      <= '0;
         held_q    <= 1'b0;
         enemy_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (frame_start && state_q != IDLE) overrun_q <= 1'b1;
         if (frame_start && state_q == IDLE) begin
            prow_q <= player_row;
            bx_q   <= bullet_x;
            by_q   <= bullet_y;
            bc_q   <= bullet_color;
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
         end
         // RAM data is captured on the first WRITE cycle so stalls cannot disturb it
         if (state_q == WRITE && !held_q) begin
            held_q  <= 1'b1;
            enemy_q <= enemy_rd_data;
         end
         if (accept) begin
            held_q <= 1'b0;
            if (!is_last) begin
               addr_q <= addr_q + AW'(1);
               if (col_q == LAST_COL) begin
                  col_q <= '0;
                  row_q <= row_q + YW'(1);
               end else begin
                  col_q <= col_q + XW'(1);
               end
            end
         end
      end
   end

   always_comb begin
      er            = 32'(row_q >> 1);
      ec            = (32'(col_q) - 32'(ENEMY_COL_MIN)) >> 1;
      is_enemy      = 1'b0;
      enemy_rd_addr = '0;
      if (row_q[0] && !col_q[0] && 32'(col_q) >= 32'(ENEMY_COL_MIN) &&
          er < 32'(ENEMY_ROWS) && ec < 32'(ENEMY_COLS)) begin
         is_enemy      = 1'b1;
         enemy_rd_addr = EAW'(er * 32'(ENEMY_COLS) + ec);
      end
   end

   always_comb begin
      fixed_hit   = 1'b1;
      fixed_color = '0;
      if (col_q == '0) begin
         fixed_color = HOME_COLOR;
      end else if (col_q == PCOL && row_q == prow_q) begin
         fixed_color = PLAYER_COLOR;
      end else begin
         fixed_hit = 1'b0;
         // highest index first so the lowest matching channel overwrites last
         for (int i = NUM_BULLETS-1; i >= 0; i--) begin
            if (bx_q[i*XW +: XW] == col_q && by_q[i*YW +: YW] == row_q &&
                bc_q[i*COLOR_W +: COLOR_W] != '0) begin
               fixed_hit   = 1'b1;
               fixed_color = bc_q[i*COLOR_W +: COLOR_W];
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      wr.wr_valid = 1'b0;
      wr.wr_color = '0;
      frame_done  = 1'b0;
      accept      = 1'b0;
      case (state_q)
         IDLE:  if (frame_start) state_d = FETCH;
         FETCH: state_d = WRITE;
         WRITE: begin
            wr.wr_valid = 1'b1;
            if (fixed_hit)     wr.wr_color = fixed_color;
            else if (is_enemy) wr.wr_color = held_q ? enemy_q : enemy_rd_data;
            if (wr.wr_ready) begin
               accept  = 1'b1;
               state_d = is_last ? DONE : FETCH;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tile_frame_renderer.sv
// Directed bench for tile_frame_renderer: renders frames and checks captured tile colours and protocol.
module tb_tile_frame_renderer;
   localparam int NT = 192;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic [3:0]  player_row = 4'd3;
   logic [11:0] bullet_x = '0;
   logic [11:0] bullet_y = '0;
   logic [35:0] bullet_color = '0;
   logic [4:0]  enemy_rd_addr;
   logic [11:0] enemy_rd_data = '0;
   logic        busy, frame_done, overrun;

   tile_frame_renderer_if #(.AW(8), .COLOR_W(12)) wr_bus ();

   tile_frame_renderer dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .player_row(player_row),
      .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_color(bullet_color),
      .enemy_rd_addr(enemy_rd_addr), .enemy_rd_data(enemy_rd_data), .wr(wr_bus),
      .busy(busy), .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // enemy RAM model: contents are address + 1, one-cycle read latency
   always @(posedge clk) enemy_rd_data <= 12'(enemy_rd_addr) + 12'd1;

   logic [11:0] mem [NT];
   int wcnt [NT];
   int nwr, order_err, stab_err, done_cyc, done_pulses;
   int compared = 0;
   int mismatched = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0 plain, 1 player_row change mid-frame, 2 frame_start at tile 50,
   // 3 reset at tile 100, 4 frame_start during DONE
   task automatic run_frame(input int mode, input bit rand_ready);
      bit          prev_stall = 1'b0;
      bit          pulsed = 1'b0;
      logic [7:0]  paddr = '0;
      logic [11:0] pcolor = '0;
      nwr = 0; order_err = 0; stab_err = 0; done_cyc = 0; done_pulses = 0;
      for (int i = 0; i < NT; i++) begin
         wcnt[i] = 0;
         mem[i]  = 'x;
      end
      @(negedge clk);
      for (int cyc = 1; cyc <= 3000; cyc++) begin
         if (cyc > 1) @(negedge clk);
         frame_start = (cyc == 1) || (mode == 4 && cyc == 386);
         if (mode == 2 && nwr == 50 && !pulsed) begin
            frame_start = 1'b1;
            pulsed = 1'b1;
         end
         if (mode == 1 && nwr == 20) player_row = 4'd6;
         wr_bus.wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (mode == 3 && nwr == 100) begin
            rst_n = 1'b0;
            wr_bus.wr_ready = 1'b0;
            @(negedge clk);
            check("rst_wr_valid", 32'(wr_bus.wr_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_overrun", 32'(overrun), 32'd0);
            check("rst_writes", nwr, 100);
            rst_n = 1'b1;
            return;
         end
         if (prev_stall && (wr_bus.wr_valid !== 1'b1 || wr_bus.wr_addr !== paddr ||
                            wr_bus.wr_color !== pcolor)) stab_err++;
         if (wr_bus.wr_valid && wr_bus.wr_ready) begin
            if (32'(wr_bus.wr_addr) != nwr) order_err++;
            if (32'(wr_bus.wr_addr) < NT) begin
               mem[wr_bus.wr_addr]  = wr_bus.wr_color;
               wcnt[wr_bus.wr_addr] = wcnt[wr_bus.wr_addr] + 1;
            end
            nwr++;
         end
         prev_stall = wr_bus.wr_valid && !wr_bus.wr_ready;
         paddr      = wr_bus.wr_addr;
         pcolor     = wr_bus.wr_color;
         if (frame_done) begin
            done_pulses++;
            if (done_cyc == 0) done_cyc = cyc;
         end
         if (done_cyc != 0 && cyc == done_cyc + 3) break;
      end
      frame_start = 1'b0;
      if (done_cyc == 0) check("frame_timeout", 32'd1, 32'd0);
   endtask

   function automatic int count_once();
      int bad = 0;
      for (int i = 0; i < NT; i++) if (wcnt[i] != 1) bad++;
      return bad;
   endfunction

   function automatic int count_color(input logic [11:0] c);
      int n = 0;
      for (int i = 0; i < NT; i++) if (mem[i] === c) n++;
      return n;
   endfunction

   initial begin
      wr_bus.wr_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_wr_valid", 32'(wr_bus.wr_valid), 32'd0);
      check("reset_wr_addr", 32'(wr_bus.wr_addr), 32'd0);
      check("reset_wr_color", 32'(wr_bus.wr_color), 32'd0);
      check("reset_enemy_addr", 32'(enemy_rd_addr), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_frame_done", 32'(frame_done), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;

      // plain frame, player on row 3, no bullets
      run_frame(0, 1'b0);
      check("a_writes", nwr, NT);
      check("a_order", order_err, 0);
      check("a_done_cycle", done_cyc, 386);
      check("a_done_pulses", done_pulses, 1);
      check("a_home_0", 32'(mem[0]), 32'h282);
      check("a_home_16", 32'(mem[16]), 32'h282);
      check("a_player_49", 32'(mem[49]), 32'hFFF);
      check("a_enemy_20", 32'(mem[20]), 32'h001);
      check("a_enemy_158", 32'(mem[158]), 32'h01E);
      check("a_blank_31", 32'(mem[31]), 32'h000);
      check("a_blank_19", 32'(mem[19]), 32'h000);
      check("a_row11_180", 32'(mem[180]), 32'h000);
      check("a_last_191", 32'(mem[191]), 32'h000);
      check("a_busy_after", 32'(busy), 32'd0);
      check("a_overrun", 32'(overrun), 32'd0);

      // bullets 0 and 1 on the same tile, bullet 2 inactive
      bullet_x     = {4'd7, 4'd5, 4'd5};
      bullet_y     = {4'd7, 4'd2, 4'd2};
      bullet_color = {12'h000, 12'h0F0, 12'hF00};
      run_frame(0, 1'b0);
      check("b_bullet_37", 32'(mem[37]), 32'hF00);
      check("b_inactive_119", 32'(mem[119]), 32'h000);

      // random stalls; bullet on column 0, plain bullet, bullet over an enemy slot
      bullet_x     = {4'd8, 4'd6, 4'd0};
      bullet_y     = {4'd3, 4'd4, 4'd4};
      bullet_color = {12'h00F, 12'h0F0, 12'hF00};
      run_frame(0, 1'b1);
      check("c_writes", nwr, NT);
      check("c_order", order_err, 0);
      check("c_once", count_once(), 0);
      check("c_stable", stab_err, 0);
      check("c_done_pulses", done_pulses, 1);
      check("c_home_64", 32'(mem[64]), 32'h282);
      check("c_bullet_70", 32'(mem[70]), 32'h0F0);
      check("c_bullet_enemy_56", 32'(mem[56]), 32'h00F);
      check("c_old_bullet_37", 32'(mem[37]), 32'h000);
      check("c_enemy_20", 32'(mem[20]), 32'h001);

      // player_row moves mid-frame; shadow keeps row 3
      bullet_color = '0;
      player_row   = 4'd3;
      run_frame(1, 1'b0);
      check("d_player_49", 32'(mem[49]), 32'hFFF);
      check("d_no_97", 32'(mem[97]), 32'h000);
      check("d_player_count", count_color(12'hFFF), 1);
      run_frame(0, 1'b0);
      check("e_player_97", 32'(mem[97]), 32'hFFF);
      check("e_no_49", 32'(mem[49]), 32'h000);

      // frame_start while busy
      run_frame(2, 1'b0);
      check("f_writes", nwr, NT);
      check("f_done_pulses", done_pulses, 1);
      check("f_done_cycle", done_cyc, 386);
      check("f_overrun", 32'(overrun), 32'd1);

      // reset mid-frame, then a full frame from address 0
      run_frame(3, 1'b0);
      run_frame(0, 1'b0);
      check("g_writes", nwr, NT);
      check("g_order", order_err, 0);
      check("g_home_0", 32'(mem[0]), 32'h282);
      check("g_overrun", 32'(overrun), 32'd0);

      // frame_start in the DONE cycle is dropped
      run_frame(4, 1'b0);
      check("h_writes", nwr, NT);
      check("h_overrun", 32'(overrun), 32'd1);
      check("h_busy_after", 32'(busy), 32'd0);
      check("h_valid_after", 32'(wr_bus.wr_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/tile_frame_renderer.md
Name: tile_frame_renderer

Overview:
- Sequential, parametrised successor to the combinational per-pixel tile colour generator.
- On each frame-start strobe, snapshots the game state and walks every tile of a COLS x ROWS grid in raster order.
- Resolves each tile's colour by fixed priority and writes it to the tile colour memory over a valid/ready write port.
- Enemy colours are fetched from an external synchronous-read enemy RAM instead of a wide input array; bullet count and grid size are parameters.

Parameters:
COLS, 16, tile columns per frame
ROWS, 12, tile rows per frame
NUM_BULLETS, 3, bullet channels
ENEMY_ROWS, 5, enemy RAM rows
ENEMY_COLS, 6, enemy RAM columns
ENEMY_COL_MIN, 4, first tile column that can hold an enemy (even)
PLAYER_COL, 1, tile column of player
COLOR_W, 12, RGB444 colour width
HOME_COLOR, 12'h282, colour of tile column 0
PLAYER_COLOR, 12'hFFF, player colour
Derived: XW=clog2(COLS), YW=clog2(ROWS), AW=clog2(COLS*ROWS), EAW=clog2(ENEMY_ROWS*ENEMY_COLS)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
frame_start  in  1  one-cycle strobe; begins a frame render
player_row  in  YW  player tile row
bullet_x  in  NUM_BULLETS*XW  packed bullet columns, channel i at [i*XW +: XW]
bullet_y  in  NUM_BULLETS*YW  packed bullet rows
bullet_color  in  NUM_BULLETS*COLOR_W  packed bullet colours; 0 = inactive
enemy_rd_addr  out  EAW  enemy RAM read address
enemy_rd_data  in  COLOR_W  enemy colour, valid 1 cycle after address
wr_valid  out  1  tile write request
wr_ready  in  1  memory accepts write
wr_addr  out  AW  tile index = row*COLS+col
wr_color  out  COLOR_W  tile colour
busy  out  1  high from frame accept until DONE exits
frame_done  out  1  one-cycle pulse after last tile accepted
overrun  out  1  sticky: frame_start seen while busy

Behaviour:
- Reset (rst_n=0 at clk edge) values: state IDLE; wr_valid=0; wr_addr=0; wr_color=0; enemy_rd_addr=0; busy=0; frame_done=0; overrun=0. Reset mid-frame aborts the frame; no further writes are issued.
- FSM states:
  - IDLE: on frame_start, latch player_row and all bullet inputs into shadow registers; col=row=0; go to FETCH; busy=1 from the next cycle.
  - FETCH (1 cycle): drive enemy_rd_addr for the current tile; go to WRITE.
  - WRITE: wr_valid=1 with stable wr_addr/wr_color until wr_ready. On accept: if last tile (row=ROWS-1, col=COLS-1), go to DONE; else advance col (wrap to 0 with row+1) and go to FETCH.
  - DONE: frame_done=1 for exactly one cycle; busy falls; return to IDLE.
- Throughput: 2 cycles per tile minimum (wr_ready held high), so a frame takes 2*COLS*ROWS+2 cycles from frame_start to frame_done.
- Colour priority, first match wins:
  - col==0 -> HOME_COLOR.
  - col==PLAYER_COL and row==player_row -> PLAYER_COLOR.
  - Bullet i, lowest index first: x==col, y==row, color!=0 -> bullet colour.
  - Enemy slot: row odd, col even, col>=ENEMY_COL_MIN, er=row/2 < ENEMY_ROWS, ec=(col-ENEMY_COL_MIN)/2 < ENEMY_COLS -> enemy_rd_data.
  - Otherwise 0.
- enemy_rd_addr = er*ENEMY_COLS+ec when the tile is an enemy slot, else 0. enemy_rd_data is sampled in the first WRITE cycle and held while stalled.
- Out-of-range player_row or bullet coordinates never match and are not errors.
- Shadowed inputs are frozen for the whole frame; input changes mid-frame take effect only at the next frame.
- frame_start while busy (including DONE) is ignored and sets overrun. overrun clears only on reset.
- frame_start in the same cycle the FSM is in DONE is ignored, even though IDLE follows.

Test Plan:
- Default parameters, frame_start, wr_ready=1, no bullets, player_row=3, enemy RAM filled with addr+1 -> 192 writes. Addr 0 = 12'h282; addr 49 = 12'hFFF; addr 20 (row1,col4) = enemy addr 0 -> 12'h001; addr 31 (row1,col15) = 0; frame_done at cycle 386.
- Bullets 0 and 1 both at (5,2), colours 12'hF00 and 12'h0F0; bullet 2 colour 0 at (7,7) -> addr 37 = 12'hF00; addr 119 = 0.
- Random wr_ready stalls -> wr_addr/wr_color stable while wr_valid && !wr_ready; every index written exactly once, in order 0..191.
- Change player_row from 3 to 6 mid-frame -> whole frame still shows player at addr 49 only; next frame shows it at addr 97.
- frame_start pulsed at tile 50 -> ignored, overrun=1, exactly 192 writes; overrun stays 1 after frame_done.
- rst_n=0 for one cycle at tile 100 -> next cycle wr_valid=0, busy=0, overrun=0; the following frame_start renders a full frame starting from addr 0.
